// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parameterised single-clock FIFO.
//  Generic width/depth, concurrent read+write, occupancy count,
//  almost-full/almost-empty thresholds, sticky overflow/underflow,
//  synchronous flush and an optional first-word-fall-through read port.
// Ports:
//  clk, rst_n          clock, async active-low reset
//  clr                 sync flush (pointers, count, dataout, errors)
//  we, datain          write request / data
//  re, dataout         read request / data (FWFT=0: 1-cycle latency)
//  full, empty         occupancy == DEPTH / == 0
//  almost_full/empty   count >= AF_LEVEL / count <= AE_LEVEL
//  count               occupancy 0..DEPTH
//  overflow/underflow  sticky: write while full / read while empty
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_L = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, count_q;
  logic                  ovf_q, udf_q;
  logic                  wr_ok, rd_ok;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign wr_ok = we & ~full;
  assign rd_ok = re & ~empty;

  assign count        = count_q;
  assign almost_full  = (count_q >= AF_L);
  assign almost_empty = (count_q <= AE_L);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_ok) rd_ptr <= rd_ptr + ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
      if (we && full)  ovf_q <= 1'b1;
      if (re && empty) udf_q <= 1'b1;
    end
  end

  // Storage is not reset; rst_n gates the write so a write racing reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr && rst_n) mem[wr_ptr[ADDR_WIDTH-1:0]] <= datain;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible without a request; empty forces zero.
      assign dataout = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     dout_q <= '0;
        else if (clr)   dout_q <= '0;
        else if (rd_ok) dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      assign dataout = dout_q;
    end
  endgenerate

endmodule
